// File: rtl/muldiv_fu.sv
// muldiv_fu: RV32M multiply/divide functional unit driving one CDB lane.
// One op in flight. Accept -> BUSY (32 iterations) -> DONE (one-cycle CDB pulse) -> IDLE.
// Divide-by-zero and signed overflow skip BUSY and go straight to DONE.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a 2-stage 33x33 signed multiplier.
module muldiv_fu #(
  parameter int PHY_IDX_W = 6,
  parameter int ROB_IDX_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [2:0]           issue_op,
  input  logic [31:0]          issue_rs1_value,
  input  logic [31:0]          issue_rs2_value,
  input  logic [PHY_IDX_W-1:0] issue_rd_phy,
  input  logic [4:0]           issue_rd_arch,
  input  logic [ROB_IDX_W-1:0] issue_rob_id,
  output logic                 cdb_valid,
  output logic [ROB_IDX_W-1:0] cdb_rob_id,
  output logic [PHY_IDX_W-1:0] cdb_rd_phy,
  output logic [4:0]           cdb_rd_arch,
  output logic [31:0]          cdb_rd_value
);

  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_MULP, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [63:0]            acc_q, acc_d;     // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic [31:0]            dvs_q, dvs_d;     // multiplicand or divisor magnitude
  op_e                    op_q, op_d;
  logic                   neg_q, neg_d;     // product/quotient needs negation
  logic                   neg_rem_q, neg_rem_d;
  logic [ROB_IDX_W-1:0]   rob_q, rob_d;
  logic [PHY_IDX_W-1:0]   phy_q, phy_d;
  logic [4:0]             arch_q, arch_d;
  logic                   cdb_valid_q, cdb_valid_d;
  logic [ROB_IDX_W-1:0]   cdb_rob_q, cdb_rob_d;
  logic [PHY_IDX_W-1:0]   cdb_phy_q, cdb_phy_d;
  logic [4:0]             cdb_arch_q, cdb_arch_d;
  logic [31:0]            cdb_val_q, cdb_val_d;

`ifdef MULDIV_FAST_MUL_EN
  logic [32:0]            fm_a_q, fm_a_d;
  logic [32:0]            fm_b_q, fm_b_d;
  logic signed [63:0]     fm_prod;
`endif

  // operand preparation from the issue bus
  logic        a_signed, b_signed, a_neg, b_neg, is_div, div_zero, div_ovf;
  logic [31:0] a_mag, b_mag, special_val;

  // iteration datapath
  logic [32:0] mul_sum;
  logic [32:0] div_top;
  logic [31:0] div_sub;
  logic        div_ge;
  logic [63:0] step_acc, prod_fix;
  logic [31:0] quot_fix, rem_fix, result;

  assign issue_ready = (state_q == S_IDLE) && !rst;

  // Signedness per op, magnitudes, and special-case divide detection
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_e'(issue_op))
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      OP_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
    a_neg       = a_signed & issue_rs1_value[31];
    b_neg       = b_signed & issue_rs2_value[31];
    a_mag       = a_neg ? (32'd0 - issue_rs1_value) : issue_rs1_value;
    b_mag       = b_neg ? (32'd0 - issue_rs2_value) : issue_rs2_value;
    is_div      = issue_op[2];
    div_zero    = is_div && (issue_rs2_value == '0);
    div_ovf     = is_div && !issue_op[0] && (issue_rs1_value == 32'h8000_0000) &&
                  (issue_rs2_value == '1);
    if (div_zero) special_val = issue_op[1] ? issue_rs1_value : '1;
    else          special_val = issue_op[1] ? '0 : 32'h8000_0000;
  end

  // One shift-add or restoring-divide step, plus sign fix-up of the final value
  always_comb begin
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);
    div_top = acc_q[63:31];
    div_ge  = (div_top >= {1'b0, dvs_q});
    div_sub = div_top[31:0] - dvs_q;
    if (op_q[2]) step_acc = {(div_ge ? div_sub : div_top[31:0]), acc_q[30:0], div_ge};
    else         step_acc = {mul_sum, acc_q[31:1]};
    prod_fix = neg_q ? (64'd0 - step_acc) : step_acc;
    quot_fix = neg_q ? (32'd0 - step_acc[31:0]) : step_acc[31:0];
    rem_fix  = neg_rem_q ? (32'd0 - step_acc[63:32]) : step_acc[63:32];
    case (op_q)
      OP_MUL:                      result = prod_fix[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_fix[63:32];
      OP_DIV, OP_DIVU:             result = quot_fix;
      default:                     result = rem_fix;
    endcase
  end

`ifdef MULDIV_FAST_MUL_EN
  // Operands are already sign/zero extended to 33 bits; the low 64 product bits are exact
  always_comb begin
    fm_prod = $signed({{31{fm_a_q[32]}}, fm_a_q}) * $signed({{31{fm_b_q[32]}}, fm_b_q});
  end
`endif

  // Next-state and register updates for the FSM and the CDB output registers
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    dvs_d       = dvs_q;
    op_d        = op_q;
    neg_d       = neg_q;
    neg_rem_d   = neg_rem_q;
    rob_d       = rob_q;
    phy_d       = phy_q;
    arch_d      = arch_q;
    cdb_valid_d = 1'b0;
    cdb_rob_d   = cdb_rob_q;
    cdb_phy_d   = cdb_phy_q;
    cdb_arch_d  = cdb_arch_q;
    cdb_val_d   = cdb_val_q;
`ifdef MULDIV_FAST_MUL_EN
    fm_a_d      = fm_a_q;
    fm_b_d      = fm_b_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (issue_valid && issue_ready) begin
          op_d   = op_e'(issue_op);
          rob_d  = issue_rob_id;
          phy_d  = issue_rd_phy;
          arch_d = issue_rd_arch;
          if (div_zero || div_ovf) begin
            state_d     = S_DONE;
            cdb_valid_d = 1'b1;
            cdb_val_d   = special_val;
            cdb_rob_d   = issue_rob_id;
            cdb_phy_d   = issue_rd_phy;
            cdb_arch_d  = issue_rd_arch;
          end
`ifdef MULDIV_FAST_MUL_EN
          else if (!is_div) begin
            fm_a_d  = {a_signed & issue_rs1_value[31], issue_rs1_value};
            fm_b_d  = {b_signed & issue_rs2_value[31], issue_rs2_value};
            state_d = S_MULP;
          end
`endif
          else begin
            state_d   = S_BUSY;
            cnt_d     = '0;
            acc_d     = {32'd0, (is_div ? a_mag : b_mag)};
            dvs_d     = is_div ? b_mag : a_mag;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
          end
        end
      end
      S_BUSY: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d     = S_DONE;
          cdb_valid_d = 1'b1;
          cdb_val_d   = result;
          cdb_rob_d   = rob_q;
          cdb_phy_d   = phy_q;
          cdb_arch_d  = arch_q;
        end
      end
      S_MULP: begin
`ifdef MULDIV_FAST_MUL_EN
        state_d     = S_DONE;
        cdb_valid_d = 1'b1;
        cdb_val_d   = (op_q == OP_MUL) ? fm_prod[31:0] : fm_prod[63:32];
        cdb_rob_d   = rob_q;
        cdb_phy_d   = phy_q;
        cdb_arch_d  = arch_q;
`else
        state_d     = S_IDLE;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      dvs_q       <= '0;
      op_q        <= OP_MUL;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      rob_q       <= '0;
      phy_q       <= '0;
      arch_q      <= '0;
      cdb_valid_q <= 1'b0;
      cdb_rob_q   <= '0;
      cdb_phy_q   <= '0;
      cdb_arch_q  <= '0;
      cdb_val_q   <= '0;
`ifdef MULDIV_FAST_MUL_EN
      fm_a_q      <= '0;
      fm_b_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      dvs_q       <= dvs_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      neg_rem_q   <= neg_rem_d;
      rob_q       <= rob_d;
      phy_q       <= phy_d;
      arch_q      <= arch_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_rob_q   <= cdb_rob_d;
      cdb_phy_q   <= cdb_phy_d;
      cdb_arch_q  <= cdb_arch_d;
      cdb_val_q   <= cdb_val_d;
`ifdef MULDIV_FAST_MUL_EN
      fm_a_q      <= fm_a_d;
      fm_b_q      <= fm_b_d;
`endif
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_rob_id   = cdb_rob_q;
  assign cdb_rd_phy   = cdb_phy_q;
  assign cdb_rd_arch  = cdb_arch_q;
  assign cdb_rd_value = cdb_val_q;

endmodule

// File: tb/tb_muldiv_fu.sv
// Testbench for muldiv_fu: scoreboard of expected CDB broadcasts (value, tags, completion cycle).
module tb_muldiv_fu;

  localparam int PHY_IDX_W = 6;
  localparam int ROB_IDX_W = 5;
`ifdef MULDIV_FAST_MUL_EN
  localparam int unsigned MUL_LAT = 2;
`else
  localparam int unsigned MUL_LAT = 33;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 issue_valid = 1'b0;
  logic                 issue_ready;
  logic [2:0]           issue_op = '0;
  logic [31:0]          issue_rs1_value = '0;
  logic [31:0]          issue_rs2_value = '0;
  logic [PHY_IDX_W-1:0] issue_rd_phy = '0;
  logic [4:0]           issue_rd_arch = '0;
  logic [ROB_IDX_W-1:0] issue_rob_id = '0;
  logic                 cdb_valid;
  logic [ROB_IDX_W-1:0] cdb_rob_id;
  logic [PHY_IDX_W-1:0] cdb_rd_phy;
  logic [4:0]           cdb_rd_arch;
  logic [31:0]          cdb_rd_value;

  muldiv_fu #(.PHY_IDX_W(PHY_IDX_W), .ROB_IDX_W(ROB_IDX_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_op        (issue_op),
    .issue_rs1_value (issue_rs1_value),
    .issue_rs2_value (issue_rs2_value),
    .issue_rd_phy    (issue_rd_phy),
    .issue_rd_arch   (issue_rd_arch),
    .issue_rob_id    (issue_rob_id),
    .cdb_valid       (cdb_valid),
    .cdb_rob_id      (cdb_rob_id),
    .cdb_rd_phy      (cdb_rd_phy),
    .cdb_rd_arch     (cdb_rd_arch),
    .cdb_rd_value    (cdb_rd_value)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0]          val;
    logic [ROB_IDX_W-1:0] rob;
    logic [PHY_IDX_W-1:0] phy;
    logic [4:0]           arch;
    int unsigned          done;
  } exp_t;

  exp_t q[$];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub;
    logic signed [31:0] as32, bs32, r32;
    logic [63:0]        p;
    logic               ovf;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    as32 = a;
    bs32 = b;
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p    = '0;
    r32  = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        r32 = as32 / bs32;
        return r32;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        r32 = as32 % bs32;
        return r32;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int unsigned lat_of(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    if (op[2] && ((b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    if (!op[2]) return MUL_LAT;
    return 33;
  endfunction

  // Record the op currently on the issue bus as accepted at the coming edge
  task automatic expect_current(input logic [31:0] exp_val);
    exp_t e;
    e.val  = exp_val;
    e.rob  = issue_rob_id;
    e.phy  = issue_rd_phy;
    e.arch = issue_rd_arch;
    e.done = cyc + lat_of(issue_op, issue_rs1_value, issue_rs2_value);
    q.push_back(e);
  endtask

  task automatic set_bus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int unsigned tag);
    issue_op        = op;
    issue_rs1_value = a;
    issue_rs2_value = b;
    issue_rd_phy    = PHY_IDX_W'(tag * 3 + 1);
    issue_rd_arch   = 5'(tag + 7);
    issue_rob_id    = ROB_IDX_W'(tag);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_val, input int unsigned tag);
    int unsigned n = 0;
    issue_valid = 1'b1;
    set_bus(op, a, b, tag);
    while (!issue_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!issue_ready) check("issue_timeout", 32'(issue_ready), 32'd1);
    else expect_current(exp_val);
    @(negedge clk);
    issue_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // CDB monitor: every pulse must match the oldest outstanding op
  exp_t mon_e;
  logic ready_next_chk = 1'b0;
  always @(negedge clk) begin
    if (ready_next_chk) begin
      check("ready_after_done", 32'(issue_ready), 32'd1);
      ready_next_chk = 1'b0;
    end
    if (cdb_valid) begin
      if (q.size() == 0) begin
        check("spurious_cdb", 32'(cdb_valid), 32'd0);
      end else begin
        mon_e = q.pop_front();
        check("cdb_value", cdb_rd_value, mon_e.val);
        check("cdb_rob",   32'(cdb_rob_id), 32'(mon_e.rob));
        check("cdb_phy",   32'(cdb_rd_phy), 32'(mon_e.phy));
        check("cdb_arch",  32'(cdb_rd_arch), 32'(mon_e.arch));
        check("cdb_cycle", cyc, mon_e.done);
        check("ready_in_done", 32'(issue_ready), 32'd0);
        ready_next_chk = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned acc_cnt;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready",     32'(issue_ready), 32'd0);
    check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    check("rst_value",     cdb_rd_value, 32'd0);
    check("rst_rob",       32'(cdb_rob_id), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(issue_ready), 32'd1);

    // directed cases
    drive_op(3'd0, 32'd7, 32'd6, 32'd42, 0);
    drive_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1);
    drive_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    drive_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);
    drive_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 4);
    drive_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 5);
    drive_op(3'd5, 32'd100, 32'd7, 32'd14, 6);
    drive_op(3'd7, 32'd100, 32'd7, 32'd2, 7);
    drive_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 8);
    drive_op(3'd6, 32'd5, 32'd0, 32'd5, 9);
    drive_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 10);
    drive_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 11);
    drain();

    // random operands against the reference model
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 4 == 0) ? 32'd0 : $urandom;
      drive_op(rop, ra, rb, ref_result(rop, ra, rb), 20 + i);
    end
    drain();

    // valid held high with a new op every cycle; only ops seen while ready are taken
    acc_cnt = 0;
    issue_valid = 1'b1;
    for (int i = 0; i < 400 && acc_cnt < 6; i++) begin
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'd0 : $urandom;
      set_bus(3'(i), ra, rb, 40 + i);
      if (issue_ready) begin
        expect_current(ref_result(3'(i), ra, rb));
        acc_cnt++;
      end
      @(negedge clk);
    end
    issue_valid = 1'b0;
    check("hold_accepts", acc_cnt, 32'd6);
    drain();

    // reset in the middle of a divide abandons it
    drive_op(3'd4, 32'd1000, 32'd3, 32'd333, 3);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    check("ready_in_rst", 32'(issue_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_post_rst", 32'(issue_ready), 32'd1);
    check("post_rst_rob",   32'(cdb_rob_id), 32'd0);
    check("post_rst_value", cdb_rd_value, 32'd0);
    repeat (40) @(negedge clk);
    drive_op(3'd7, 32'd100, 32'd7, 32'd2, 12);
    drive_op(3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 13);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
